// File: rtl/alu_control_unit.sv
// Sequencing controller for a combinational 32-bit ALU: accepts one instruction,
// reads operands from its register file, drives the ALU, and writes back result and flags.
module alu_control_unit #(
    parameter int REG_AW    = 3,
    parameter bit USE_CARRY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [5:0]        alu_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic              alu_c,
    input  logic [31:0]       alu_ans1,
    input  logic              alu_ans2,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic              err,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [1:0]        dbg_state
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LOAD = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SUB  = 6'b010001;
    localparam logic [5:0] OP_EQ   = 6'b100000;
    localparam logic [5:0] OP_NE   = 6'b100001;
    localparam logic [5:0] OP_LE   = 6'b100010;
    localparam logic [5:0] OP_GT   = 6'b100011;
    localparam logic [5:0] OP_SLL  = 6'b110000;
    localparam logic [5:0] OP_SRL  = 6'b110001;
    localparam logic [5:0] OP_SRA  = 6'b110010;

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] regs_q [NREG];
    logic [31:0] regs_d [NREG];
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;
    logic [31:0] hold_ans1_q, hold_ans1_d;
    logic        hold_c_q, hold_c_d;
    logic        hold_z_q, hold_z_d;
    logic        hold_n_q, hold_n_d;

    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic        is_alu, is_addsub, is_load, is_nop, is_illegal;
    logic        unused_instr_bit;

    assign op               = instr_q[31:26];
    assign rd               = instr_q[25:23];
    assign rs1              = instr_q[22:20];
    assign rs2              = instr_q[19:17];
    assign imm              = instr_q[15:0];
    assign unused_instr_bit = instr_q[16];

    always_comb begin
        is_addsub = (op == OP_ADD) || (op == OP_SUB);
        is_alu    = is_addsub ||
                    (op == OP_EQ)  || (op == OP_NE)  || (op == OP_LE) || (op == OP_GT) ||
                    (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        is_load    = (op == OP_LOAD);
        is_nop     = (op == OP_NOP);
        is_illegal = !(is_alu || is_load || is_nop);
    end

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, so the word is
    // held in instr_q and the input is ignored until the unit returns to IDLE.
    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WB);
    assign err         = (state_q == S_WB) && is_illegal;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign dbg_data    = regs_q[dbg_addr];
    assign dbg_state   = state_q;

    always_comb begin
        alu_op = 6'd0;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_c  = 1'b0;
        if (state_q == S_EXEC) begin
            alu_op = op;
            alu_a  = regs_q[rs1];
            alu_b  = regs_q[rs2];
            alu_c  = USE_CARRY && is_addsub && flag_c_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        regs_d      = regs_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        hold_ans1_d = hold_ans1_q;
        hold_c_d    = hold_c_q;
        hold_z_d    = hold_z_q;
        hold_n_d    = hold_n_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = is_alu ? S_EXEC : S_WB;
            S_EXEC: begin
                hold_ans1_d = alu_ans1;
                hold_c_d    = alu_ans2;
                hold_z_d    = alu_z;
                hold_n_d    = alu_n;
                state_d     = S_WB;
            end
            S_WB: begin
                if (is_alu) begin
                    regs_d[rd] = hold_ans1_q;
                    flag_z_d   = hold_z_q;
                    flag_n_d   = hold_n_q;
                    // ans2 is only meaningful for ADD/SUB
                    if (is_addsub) flag_c_d = hold_c_q;
                end else if (is_load) begin
                    regs_d[rd] = {16'd0, imm};
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= 32'd0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            hold_ans1_q <= 32'd0;
            hold_c_q    <= 1'b0;
            hold_z_q    <= 1'b0;
            hold_n_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            regs_q      <= regs_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            hold_ans1_q <= hold_ans1_d;
            hold_c_q    <= hold_c_d;
            hold_z_q    <= hold_z_d;
            hold_n_q    <= hold_n_d;
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: behavioural ALU responder, register/flag reference
// model, directed scenarios and randomized instruction streams.
module tb_alu_control_unit;

    localparam bit USE_CARRY = 1'b1;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LOAD = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SUB  = 6'b010001;
    localparam logic [5:0] OP_EQ   = 6'b100000;
    localparam logic [5:0] OP_NE   = 6'b100001;
    localparam logic [5:0] OP_LE   = 6'b100010;
    localparam logic [5:0] OP_GT   = 6'b100011;
    localparam logic [5:0] OP_SLL  = 6'b110000;
    localparam logic [5:0] OP_SRL  = 6'b110001;
    localparam logic [5:0] OP_SRA  = 6'b110010;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_c;
    logic [31:0] alu_ans1;
    logic        alu_ans2, alu_z, alu_n;
    logic        done, err;
    logic        flag_c, flag_z, flag_n;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [1:0]  dbg_state;

    alu_control_unit #(.REG_AW(3), .USE_CARRY(USE_CARRY)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_ans1(alu_ans1), .alu_ans2(alu_ans2), .alu_z(alu_z), .alu_n(alu_n),
        .done(done), .err(err),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ALU behaviour: returns {carry/borrow, z, n, ans1}
    function automatic logic [34:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        logic [32:0] w;
        logic [31:0] r;
        logic        co;
        r  = 32'd0;
        co = 1'b0;
        w  = 33'd0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b} + {32'd0, c}; r = w[31:0]; co = w[32]; end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b} - {32'd0, c}; r = w[31:0]; co = w[32]; end
            OP_EQ:  r = {31'd0, a == b};
            OP_NE:  r = {31'd0, a != b};
            OP_LE:  r = {31'd0, a <= b};
            OP_GT:  r = {31'd0, a > b};
            OP_SLL: r = a << b;
            OP_SRL: r = a >> b;
            OP_SRA: r = $signed(a) >>> b;
            default: r = 32'd0;
        endcase
        return {co, r == 32'd0, r[31], r};
    endfunction

    assign {alu_ans2, alu_z, alu_n, alu_ans1} = alu_fn(alu_op, alu_a, alu_b, alu_c);

    // reference model
    logic [31:0] m_regs [8];
    logic        m_c, m_z, m_n;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, 1'b0, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_c = 1'b0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) check_reg(tag, 3'(i), m_regs[i]);
        check({tag, "_c"}, flag_c, m_c);
        check({tag, "_z"}, flag_z, m_z);
        check({tag, "_n"}, flag_n, m_n);
    endtask

    // driver: one instruction, optionally holding instr_valid high while busy
    task automatic run_instr(input logic [31:0] w, input bit hold_valid);
        logic [5:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [31:0] ea, eb;
        logic        ec, is_alu, is_addsub, is_load, illegal;
        logic [34:0] r;
        int          n;
        op        = w[31:26];
        rd        = w[25:23];
        rs1       = w[22:20];
        rs2       = w[19:17];
        is_addsub = op inside {OP_ADD, OP_SUB};
        is_alu    = op inside {OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_SLL, OP_SRL, OP_SRA};
        is_load   = (op == OP_LOAD);
        illegal   = !(is_alu || is_load || op == OP_NOP);
        ea        = m_regs[rs1];
        eb        = m_regs[rs2];
        ec        = USE_CARRY && is_addsub && m_c;

        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        check("ready_idle", instr_ready, 1);
        @(posedge clk);
        #1;
        if (hold_valid) instr = $urandom();
        else instr_valid = 1'b0;
        n = 1;
        while (!done && n < 8) begin
            check("ready_busy", instr_ready, 0);
            if (is_alu && n == 2) begin
                check("alu_op", alu_op, op);
                check("alu_a", alu_a, ea);
                check("alu_b", alu_b, eb);
                check("alu_c", alu_c, ec);
            end else begin
                check("alu_op_quiet", alu_op, 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, is_alu ? 3 : 2);
        check("err", err, illegal);
        check("ready_wb", instr_ready, 0);

        if (is_alu) begin
            r = alu_fn(op, ea, eb, ec);
            m_regs[rd] = r[31:0];
            m_z = r[33];
            m_n = r[32];
            if (is_addsub) m_c = r[34];
        end else if (is_load) begin
            m_regs[rd] = {16'd0, w[15:0]};
        end

        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("err_pulse", err, 0);
        check("ready_after", instr_ready, 1);
        check_reg("rd_val", rd, m_regs[rd]);
        check("flag_c", flag_c, m_c);
        check("flag_z", flag_z, m_z);
        check("flag_n", flag_n, m_n);
    endtask

    initial begin
        logic [5:0] ops [12];
        logic [5:0] illegal_ops [4];
        logic [5:0] op;
        logic [15:0] imm;
        int sel;

        ops = '{OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
                OP_SLL, OP_SRL, OP_SRA, OP_LOAD, OP_NOP, OP_LOAD};
        illegal_ops = '{6'b111111, 6'b000010, 6'b010010, 6'b110011};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_c", alu_c, 0);
        check_all("rst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 1);

        // reset mid-EXEC of an ADD aborts it
        run_instr(mk(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h1234), 1'b0);
        run_instr(mk(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0055), 1'b0);
        @(negedge clk);
        instr       = mk(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_exec", alu_op, OP_ADD);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_done", done, 0);
        check("abort_alu_op", alu_op, 0);
        check_all("abort_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", instr_ready, 1);
        check("abort_no_done", done, 0);

        // carry chain
        run_instr(mk(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'hFFFF), 1'b0);
        run_instr(mk(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0001), 1'b0);
        run_instr(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0), 1'b0);
        check_reg("add_r3", 3'd3, 32'h0001_0000);
        check("add_c", flag_c, 0);
        check("add_z", flag_z, 0);
        check("add_n", flag_n, 0);

        run_instr(mk(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'd5), 1'b0);
        run_instr(mk(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'd7), 1'b0);
        run_instr(mk(OP_SUB, 3'd4, 3'd1, 3'd2, 16'h0), 1'b0);
        check_reg("sub_r4", 3'd4, 32'hFFFF_FFFE);
        check("sub_c", flag_c, 1);
        check("sub_n", flag_n, 1);
        run_instr(mk(OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0), 1'b0);
        check_reg("addc_r5", 3'd5, 32'd13);

        // compares leave flag_c alone
        run_instr(mk(OP_SUB, 3'd0, 3'd1, 3'd2, 16'h0), 1'b0);
        run_instr(mk(OP_EQ, 3'd6, 3'd1, 3'd1, 16'h0), 1'b0);
        check_reg("eq_r6", 3'd6, 32'd1);
        check("eq_z", flag_z, 0);
        check("eq_c_kept", flag_c, 1);
        run_instr(mk(OP_NE, 3'd6, 3'd1, 3'd1, 16'h0), 1'b0);
        check_reg("ne_r6", 3'd6, 32'd0);
        check("ne_z", flag_z, 1);
        check("ne_c_kept", flag_c, 1);

        run_instr(mk(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h8000), 1'b0);
        run_instr(mk(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'd16), 1'b0);
        run_instr(mk(OP_SLL, 3'd7, 3'd1, 3'd2, 16'h0), 1'b0);
        check_reg("sll_r7", 3'd7, 32'h8000_0000);
        check("sll_n", flag_n, 1);

        // illegal opcode and held valid
        run_instr(mk(6'b111111, 3'd7, 3'd1, 3'd2, 16'h1234), 1'b1);
        check_all("illegal_regs");
        run_instr(mk(OP_ADD, 3'd2, 3'd2, 3'd2, 16'h0), 1'b1);
        run_instr(mk(OP_NOP, 3'd2, 3'd2, 3'd2, 16'hBEEF), 1'b1);

        // randomized stream
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 15);
            if (sel < 12) op = ops[sel];
            else if (sel < 14) op = OP_LOAD;
            else op = illegal_ops[$urandom_range(0, 3)];
            case ($urandom_range(0, 4))
                0: imm = 16'hFFFF;
                1: imm = 16'h8000;
                2: imm = 16'($urandom_range(0, 40));
                default: imm = 16'($urandom());
            endcase
            run_instr(mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         3'($urandom_range(0, 7)), imm), 1'($urandom_range(0, 1)));
        end
        check_all("final_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
